// File: rtl/match_event_counter_pkg.sv
`default_nettype none
// ============================================================================
// match_event_counter_pkg
// Shared constants for the match event counter: BCD digit width and the
// active-low {g,f,e,d,c,b,a} seven-segment patterns for digits 0-9 and blank.
// Revision: 1.0
// ============================================================================
package match_event_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/match_event_counter_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// match_event_counter_bcd_to_7seg
// Pure combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes blank the display.
// Revision: 1.0
// ============================================================================
module match_event_counter_bcd_to_7seg
    import match_event_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    // Map one BCD digit onto its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/match_event_counter.sv
`default_nettype none
// ============================================================================
// match_event_counter
// Counts rising edges of the upstream match indication z in a two-digit BCD
// counter (00-99) with optional wrap or saturation, a one-cycle event pulse,
// a sticky overflow flag and two active-low seven-segment display outputs.
// Revision: 1.0
// ============================================================================
module match_event_counter
    import match_event_counter_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       z,
    input  logic       enable,
    input  logic       clear,
    output logic [7:0] count_bcd,
    output logic       event_pulse,
    output logic       overflow,
    output logic [6:0] seg1,
    output logic [6:0] seg0
);

    logic                z_q;
    logic                rise;
    logic                increment;
    logic [DIGIT_W-1:0]  units;
    logic [DIGIT_W-1:0]  tens;
    logic [7:0]          next_count;
    logic                at_top;

    assign units     = count_bcd[3:0];
    assign tens      = count_bcd[7:4];
    assign rise      = z & ~z_q;
    assign increment = rise & enable & ~clear;

    // BCD successor of the current count; at 99 either wrap or hold
    always_comb begin
        next_count = count_bcd;
        at_top     = 1'b0;
        if (units != 4'd9) begin
            next_count = {tens, units + 4'd1};
        end else if (tens != 4'd9) begin
            next_count = {tens + 4'd1, 4'd0};
        end else begin
            at_top     = 1'b1;
            next_count = WRAP ? 8'h00 : 8'h99;
        end
    end

    // Edge history, count, event pulse and sticky overflow; clear beats increment.
    // z_q resets high so a z already high at reset release is not an event.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            z_q         <= 1'b1;
            count_bcd   <= 8'h00;
            event_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            z_q <= z;
            if (clear) begin
                count_bcd   <= 8'h00;
                event_pulse <= 1'b0;
                overflow    <= 1'b0;
            end else if (increment) begin
                count_bcd   <= next_count;
                event_pulse <= 1'b1;
                if (at_top) begin
                    overflow <= 1'b1;
                end
            end else begin
                event_pulse <= 1'b0;
            end
        end
    end

    match_event_counter_bcd_to_7seg u_seg_tens (
        .digit (tens),
        .seg   (seg1)
    );

    match_event_counter_bcd_to_7seg u_seg_units (
        .digit (units),
        .seg   (seg0)
    );

endmodule
`default_nettype wire
